fetch_prefetch_buffer: RTL

- Upstream neighbour of the pipelined datapath's fetch stage.
- Issues sequential instruction-memory reads over a req/ack handshake, since memory latency is variable.
- Buffers returned words with their PCs in a small FIFO and presents the head entry as InstrF/PCF to the F->D pipeline register.
- On a branch/PC redirect it flushes, discards any in-flight response, and restarts fetching at the redirect target.

---
 rtl/fetch_prefetch_buffer_if.sv | 32 +++
 rtl/fetch_prefetch_buffer.sv | 122 ++++++++++++
 2 files changed

// File: rtl/fetch_prefetch_buffer_if.sv
// Bundle between the prefetch buffer, its fetch-stage consumer and instruction memory.
//
// Handshakes:
//   Fetch side  - ValidF is the producer's valid and Pop is the consumer's ready;
//                 the head entry moves only in a cycle where ValidF && Pop.
//   Memory side - ImemReq/ImemAddr are held stable from the first request cycle
//                 until the cycle ImemAck=1; ImemRData is meaningful only then,
//                 and ImemAck is ignored whenever ImemReq=0.
interface fetch_prefetch_buffer_if;
  logic        Redirect;
  logic [31:0] RedirectPC;
  logic        Pop;
  logic [31:0] InstrF;
  logic [31:0] PCF;
  logic        ValidF;
  logic        ImemReq;
  logic [31:0] ImemAddr;
  logic        ImemAck;
  logic [31:0] ImemRData;

  // Buffer side
  modport master (
    input  Redirect, RedirectPC, Pop, ImemAck, ImemRData,
    output InstrF, PCF, ValidF, ImemReq, ImemAddr
  );

  // Environment side (branch logic, fetch stage, instruction memory)
  modport slave (
    output Redirect, RedirectPC, Pop, ImemAck, ImemRData,
    input  InstrF, PCF, ValidF, ImemReq, ImemAddr
  );
endinterface

// File: rtl/fetch_prefetch_buffer.sv
// Instruction prefetch buffer: sequential imem reads with one request in flight,
// {pc, instr} FIFO feeding the fetch stage, flush-and-restart on redirect.
module fetch_prefetch_buffer #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     reset,
  fetch_prefetch_buffer_if.master  bus,
  output logic [1:0]               fsm_state
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_DISCARD = 2'd2
  } state_t;

  state_t        state;
  logic [31:0]   fetch_pc;
  logic [31:0]   req_addr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [63:0]   mem [DEPTH];

  logic issue;
  logic push;
  logic pop;
  logic valid;

  // A new request is only started with room in the FIFO, so its response can
  // always be pushed even if nothing is popped meanwhile.
  assign issue = !reset && (state == S_IDLE) && (count < DEPTH_C) && !bus.Redirect;

  assign bus.ImemReq  = issue || (!reset && (state != S_IDLE));
  assign bus.ImemAddr = (state == S_IDLE) ? fetch_pc : req_addr;

  // Responses in DISCARD and any response in a redirect cycle are dropped.
  assign push = !reset && !bus.Redirect && bus.ImemAck &&
                (issue || (state == S_WAIT));

  assign valid = !reset && (count != '0);
  assign pop   = !reset && !bus.Redirect && bus.Pop && valid;

  assign bus.ValidF = valid;
  assign bus.PCF    = valid ? mem[rd_ptr][63:32] : '0;
  assign bus.InstrF = valid ? mem[rd_ptr][31:0]  : '0;
  assign fsm_state  = state;

  // FIFO storage: the pushed PC is whatever address is on the bus this cycle.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {bus.ImemAddr, bus.ImemRData};
    end
  end

  // Fetch FSM, fetch PC and FIFO bookkeeping; redirect overrides push and pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      fetch_pc <= RESET_PC;
      req_addr <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else if (bus.Redirect) begin
      fetch_pc <= {bus.RedirectPC[31:2], 2'b00};
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      // A request still waiting for its ack must be drained before restarting.
      if ((state != S_IDLE) && !bus.ImemAck) begin
        state <= S_DISCARD;
      end else begin
        state <= S_IDLE;
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (issue) begin
            req_addr <= fetch_pc;
            if (bus.ImemAck) begin
              fetch_pc <= fetch_pc + 32'd4;
            end else begin
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (bus.ImemAck) begin
            fetch_pc <= req_addr + 32'd4;
            state    <= S_IDLE;
          end
        end
        S_DISCARD: begin
          if (bus.ImemAck) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase

      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
